acknak_dllp_rx: RTL
===================

# acknak_dllp_rx

Receive-side ACK/NAK front end for the replay buffer. Parses incoming 16-bit DLLP words, checks their CRC-16 and validates the carried sequence number against the outstanding-TLP window. It then drives the replay buffer's `ack_nack`, `seq` and `tim_out` inputs. It also owns the replay timer and the replay-number counter, and tracks the transmit sequence window from `tlp_sent` pulses.

## Interface
- `REPLAY_TIMEOUT`, default 711: replay timer expiry, in clock cycles (≥2).
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `dllp_valid` input 1: `dllp_data` carries a DLLP word this cycle.
- `dllp_sop` input 1: qualifies `dllp_valid`; marks word0 of a frame.
- `dllp_data` input 16: DLLP word.
- `tlp_sent` input 1: one-cycle pulse per new (non-replayed) TLP handed to the replay buffer.
- `ack_nack` output 2: 2'b01 ACK, 2'b10 NAK, 2'b00 none; 2'b11 is never driven.
- `seq` output 12: sequence number qualifying `ack_nack`.
- `tim_out` output 1: one-cycle replay-timeout pulse.
- `replay_rollover` output 1: one-cycle pulse when the replay count wraps 3→0.
- `crc_err` output 1: one-cycle pulse on a CRC-failed frame.
- `proto_err` output 1: one-cycle pulse on an out-of-window seq, a bad type, overflow, or an aborted frame.

## Operation
- Frame: three words.
  - word0: [15:8] type (8'h00 ACK, 8'h10 NAK); [7:4] reserved; [3:0] seq[11:8].
  - word1: [15:8] seq[7:0]; [7:0] reserved.
  - word2: CRC-16.
- CRC: polynomial 16'h100B, init 16'hFFFF, MSB-first over word0 then word1, no reflection, no final inversion. It must equal word2.
- Parser FSM states are IDLE, W1 and W2. Only words with `dllp_valid=1` are considered.
  - IDLE: a word with `dllp_sop=1` latches word0 and moves to W1. A word with sop=0 is ignored silently.
  - W1: a word with sop=0 latches word1 and moves to W2.
  - W2: a word with sop=0 completes the frame, which is evaluated, and the FSM returns to IDLE.
  - A sop=1 word in W1 or W2 aborts the frame and pulses `proto_err`. The word is treated as a new word0 and the FSM moves to W1.
- Window state:
  - `next_tx_seq` (12-bit), reset 0.
  - `acked_seq` (12-bit), reset 12'hFFF.
  - `outstanding = (next_tx_seq - 1 - acked_seq) mod 4096`.
  - `tlp_sent` increments `next_tx_seq` mod 4096. When `outstanding==4095`, `tlp_sent` is ignored and `proto_err` pulses.
- Evaluation order for a completed frame:
  1. If the CRC is wrong, pulse `crc_err` only.
  2. Else, if the type is neither ACK nor NAK, pulse `proto_err`.
  3. Else compute `d=(s-acked_seq) mod 4096`. If `d>outstanding`, the frame is dropped and `proto_err` pulses.
  4. Otherwise the frame is valid. ACK with d=0 is a duplicate and produces no output. ACK with d>0 is forward progress: it sets `acked_seq=s` and emits `ack_nack=01`, `seq=s`. NAK with any d≤outstanding sets `acked_seq=s` and emits `ack_nack=10`, `seq=s`.
- Replay timer (counter ≥10 bits):
  - Held at 0 while `outstanding==0`.
  - Otherwise increments each cycle.
  - Clears on forward-progress ACK, on NAK and on expiry.
  - Expiry occurs when the count equals `REPLAY_TIMEOUT-1`: `tim_out` pulses the next cycle and the counter clears.
- Replay count (2-bit, reset 0):
  - Increments on each `tim_out` or valid NAK.
  - Clears on a forward-progress ACK.
  - On an increment from 3: wraps to 0 and pulses `replay_rollover`.

## Timing
- All outputs are registered. Reset values: `ack_nack=00`, `seq=0`, and `tim_out`, `replay_rollover`, `crc_err`, `proto_err` all 0. Internal state resets to IDLE, with timer and replay count at 0.
- `ack_nack`/`seq`, `crc_err` and window-check `proto_err` assert in the cycle after word2 is accepted. Each asserts for exactly one cycle; `ack_nack` returns to 00 and `seq` holds its last value.
- Back-to-back frames are supported: a new word0 may arrive in the cycle after word2.
- Same-cycle `tlp_sent` and frame evaluation:
  - The window check uses pre-increment `next_tx_seq`.
  - Both updates apply.
  - A timer held at 0 starts counting the next cycle.
- Same-cycle timer expiry and forward-progress ACK: the ACK wins. `tim_out` is not pulsed, the timer clears and the replay count clears.
- Same-cycle NAK and timer expiry: `tim_out` is suppressed and the replay count increments once.
- Reset mid-frame discards the partial frame immediately (asynchronous).

## Test plan
- Reset, 3 × `tlp_sent` (seqs 0–2), then a valid ACK for seq 1 → one cycle after word2, `ack_nack=01`, `seq=12'h001`; `outstanding=1`; timer cleared.
- Same setup, ACK seq 1 again (duplicate) → no `ack_nack`; ACK seq 5 → `proto_err` pulse, `acked_seq` unchanged.
- Frame with word2 XOR 16'h0001 → `crc_err` pulse, `ack_nack` stays 00; next correct frame is accepted normally.
- `REPLAY_TIMEOUT=16`, one `tlp_sent`, no DLLPs → `tim_out` pulses 16 cycles after the count first leaves 0, repeating every 16 cycles. The fourth pulse coincides with a `replay_rollover` pulse.
- Wrap-around: drive 4095 TLPs with ACKs, so that `next_tx_seq` wraps; ACK seq 12'h001 after `next_tx_seq` reaches 2 → accepted. A `tlp_sent` with 4095 outstanding → `proto_err`.
- Abort: word0 then word0 again (sop) then word1/word2 → `proto_err` at the abort; the second frame is decoded correctly.

Source files
------------

// File: rtl/acknak_dllp_rx.sv
// acknak_dllp_rx: ACK/NAK DLLP parser, window check, replay timer and replay counter
module acknak_dllp_rx #(
    parameter int REPLAY_TIMEOUT = 711
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dllp_valid,
    input  logic        dllp_sop,
    input  logic [15:0] dllp_data,
    input  logic        tlp_sent,
    output logic [1:0]  ack_nack,
    output logic [11:0] seq,
    output logic        tim_out,
    output logic        replay_rollover,
    output logic        crc_err,
    output logic        proto_err
);
    localparam int TW = ($clog2(REPLAY_TIMEOUT) < 10) ? 10 : $clog2(REPLAY_TIMEOUT);
    localparam logic [TW-1:0] T_MAX = TW'(REPLAY_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, W1, W2} state_t;

    state_t        state, state_nxt;
    logic [15:0]   w0, w1;
    logic [11:0]   next_tx_seq, acked_seq, outstanding, s, d;
    logic [TW-1:0] timer;
    logic [1:0]    replay_cnt;
    logic          load_w0, load_w1, done, abort;
    logic          crc_ok, is_ack, is_nak, in_win, good, fwd_ack, nak_ok, frame_err;
    logic          tx_full, expire, replay_inc;

    function automatic logic [15:0] crc16(input logic [31:0] m);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 31; i >= 0; i--)
            c = {c[14:0], 1'b0} ^ ((c[15] ^ m[i]) ? 16'h100B : 16'h0000);
        return c;
    endfunction

    assign outstanding = next_tx_seq - 12'd1 - acked_seq;
    assign s           = {w0[3:0], w1[15:8]};
    assign d           = s - acked_seq;
    assign crc_ok      = crc16({w0, w1}) == dllp_data;
    assign is_ack      = w0[15:8] == 8'h00;
    assign is_nak      = w0[15:8] == 8'h10;
    assign in_win      = d <= outstanding;
    assign good        = done & crc_ok & (is_ack | is_nak) & in_win;
    assign fwd_ack     = good & is_ack & (d != 12'd0);
    assign nak_ok      = good & is_nak;
    assign frame_err   = done & crc_ok & ~good;
    assign tx_full     = outstanding == 12'hFFF;
    assign expire      = timer == T_MAX;
    // an ACK landing on the expiry cycle wins; a NAK absorbs the expiry into one increment
    assign replay_inc  = (expire & ~fwd_ack) | nak_ok;

    // parser next state: a sop word always restarts a frame, aborting any partial one
    always_comb begin
        state_nxt = state;
        load_w0   = 1'b0;
        load_w1   = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        if (dllp_valid) begin
            if (dllp_sop) begin
                load_w0   = 1'b1;
                abort     = state != IDLE;
                state_nxt = W1;
            end else if (state == W1) begin
                load_w1   = 1'b1;
                state_nxt = W2;
            end else if (state == W2) begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
        end
    end

    // parser state and frame word capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            w0    <= '0;
            w1    <= '0;
        end else begin
            state <= state_nxt;
            if (load_w0) w0 <= dllp_data;
            if (load_w1) w1 <= dllp_data;
        end
    end

    // transmit window, replay timer and replay count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            next_tx_seq <= '0;
            acked_seq   <= 12'hFFF;
            timer       <= '0;
            replay_cnt  <= '0;
        end else begin
            next_tx_seq <= next_tx_seq + {11'd0, tlp_sent & ~tx_full};
            acked_seq   <= (fwd_ack | nak_ok) ? s : acked_seq;
            timer       <= (fwd_ack | nak_ok | expire | outstanding == 12'd0) ? '0 : timer + TW'(1);
            replay_cnt  <= fwd_ack ? 2'd0 : replay_cnt + {1'b0, replay_inc};
        end
    end

    // registered one-cycle status outputs; seq holds its last qualified value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_nack        <= 2'b00;
            seq             <= '0;
            tim_out         <= 1'b0;
            replay_rollover <= 1'b0;
            crc_err         <= 1'b0;
            proto_err       <= 1'b0;
        end else begin
            ack_nack        <= {nak_ok, fwd_ack};
            seq             <= (fwd_ack | nak_ok) ? s : seq;
            tim_out         <= expire & ~fwd_ack & ~nak_ok;
            replay_rollover <= replay_inc & (&replay_cnt);
            crc_err         <= done & ~crc_ok;
            proto_err       <= abort | frame_err | (tlp_sent & tx_full);
        end
    end
endmodule
